// File: rtl/ttt_turn_sequencer.sv
// ============================================================================
//  Module   : ttt_turn_sequencer
//  Brief    : Clocked tic-tac-toe turn controller. It holds the 3x3 grid,
//             synchronizes and edge-detects the buttons, alternates turns and
//             detects a win or a full grid.
//             Optional macro TTT_COMP_PLAYER_EN adds the computer move on
//             comp_button.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module ttt_turn_sequencer #(
    parameter int SYNC_STAGES = 2
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [8:0]  cell_btn,
    input  logic        comp_button,
    output logic [17:0] cell_led,
    output logic        p1_turn,
    output logic        p2_turn,
    output logic        p1_win,
    output logic        p2_win,
    output logic        grid_full,
    output logic        move_err
);

    typedef enum logic [1:0] {
        P1_WAIT   = 2'd0,
        P2_WAIT   = 2'd1,
        CHECK     = 2'd2,
        GAME_OVER = 2'd3
    } state_t;

    state_t      r_state;
    logic [17:0] r_grid;
    logic        r_mover_p2;

    logic [8:0]  r_cell_sync [SYNC_STAGES];
    logic [8:0]  r_cell_hist;
    logic [8:0]  w_cell_press;
    logic        w_multi;
    logic [8:0]  w_empty;
    logic [8:0]  w_p1_mask;
    logic [8:0]  w_p2_mask;
    logic        w_full;
    logic        w_comp_press;
    logic [8:0]  w_comp_sel;
    logic [8:0]  w_move_sel;
    logic [1:0]  w_code;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int s = 0; s < SYNC_STAGES; s++) r_cell_sync[s] <= '0;
            r_cell_hist <= '0;
        end else begin
            r_cell_sync[0] <= cell_btn;
            for (int s = 1; s < SYNC_STAGES; s++) r_cell_sync[s] <= r_cell_sync[s-1];
            r_cell_hist <= r_cell_sync[SYNC_STAGES-1];
        end
    end

    assign w_cell_press = r_cell_sync[SYNC_STAGES-1] & ~r_cell_hist;
    // Clearing the lowest set bit leaves something only when two or more are set.
    assign w_multi      = |(w_cell_press & (w_cell_press - 9'd1));

`ifdef TTT_COMP_PLAYER_EN
    logic [SYNC_STAGES-1:0] r_comp_sync;
    logic                   r_comp_hist;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_comp_sync <= '0;
            r_comp_hist <= 1'b0;
        end else begin
            r_comp_sync <= {r_comp_sync[SYNC_STAGES-2:0], comp_button};
            r_comp_hist <= r_comp_sync[SYNC_STAGES-1];
        end
    end

    assign w_comp_press = r_comp_sync[SYNC_STAGES-1] & ~r_comp_hist;
    // Two's-complement isolate: one-hot of the lowest-index empty cell.
    assign w_comp_sel   = w_empty & (~w_empty + 9'd1);
`else
    logic w_unused_comp;
    assign w_unused_comp = comp_button;
    assign w_comp_press  = 1'b0;
    assign w_comp_sel    = '0;
`endif

    for (genvar k = 0; k < 9; k++) begin : g_cells
        assign w_empty[k]   = (r_grid[2*k +: 2] == 2'b00);
        assign w_p1_mask[k] = (r_grid[2*k +: 2] == 2'b01);
        assign w_p2_mask[k] = (r_grid[2*k +: 2] == 2'b10);
    end

    assign w_full     = ~|w_empty;
    assign w_move_sel = (|w_cell_press) ? w_cell_press : w_comp_sel;
    assign w_code     = (r_state == P2_WAIT) ? 2'b10 : 2'b01;
    assign cell_led   = r_grid;

    function automatic logic has_line(input logic [8:0] m);
        return (&m[2:0]) | (&m[5:3]) | (&m[8:6]) |
               (m[0] & m[3] & m[6]) | (m[1] & m[4] & m[7]) | (m[2] & m[5] & m[8]) |
               (m[0] & m[4] & m[8]) | (m[2] & m[4] & m[6]);
    endfunction

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state    <= P1_WAIT;
            r_grid     <= '0;
            r_mover_p2 <= 1'b0;
            p1_turn    <= 1'b1;
            p2_turn    <= 1'b0;
            p1_win     <= 1'b0;
            p2_win     <= 1'b0;
            grid_full  <= 1'b0;
            move_err   <= 1'b0;
        end else begin
            move_err <= 1'b0;
            case (r_state)
                P1_WAIT, P2_WAIT: begin
                    if (w_multi) begin
                        move_err <= 1'b1;
                    end else if ((|w_cell_press) && !(|(w_cell_press & w_empty))) begin
                        move_err <= 1'b1;
                    end else if ((|w_cell_press) ||
                                 (r_state == P2_WAIT && w_comp_press && (|w_comp_sel))) begin
                        for (int k = 0; k < 9; k++)
                            if (w_move_sel[k]) r_grid[2*k +: 2] <= w_code;
                        r_mover_p2 <= (r_state == P2_WAIT);
                        r_state    <= CHECK;
                        p1_turn    <= 1'b0;
                        p2_turn    <= 1'b0;
                    end
                end
                CHECK: begin
                    if (r_mover_p2 ? has_line(w_p2_mask) : has_line(w_p1_mask)) begin
                        if (r_mover_p2) p2_win <= 1'b1;
                        else            p1_win <= 1'b1;
                        grid_full <= w_full;
                        r_state   <= GAME_OVER;
                    end else if (w_full) begin
                        grid_full <= 1'b1;
                        r_state   <= GAME_OVER;
                    end else if (r_mover_p2) begin
                        r_state <= P1_WAIT;
                        p1_turn <= 1'b1;
                    end else begin
                        r_state <= P2_WAIT;
                        p2_turn <= 1'b1;
                    end
                end
                default: begin
                    r_state <= GAME_OVER;
                end
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_ttt_turn_sequencer.sv
// ============================================================================
//  Module   : tb_ttt_turn_sequencer
//  Brief    : Scoreboard bench for ttt_turn_sequencer; an independent game
//             model predicts each move's outcome. Honours TTT_COMP_PLAYER_EN.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_ttt_turn_sequencer;

`ifdef TTT_COMP_PLAYER_EN
    localparam bit COMP_EN = 1'b1;
`else
    localparam bit COMP_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic [8:0]  cell_btn = '0;
    logic        comp_button = 1'b0;
    logic [17:0] cell_led;
    logic        p1_turn, p2_turn, p1_win, p2_win, grid_full, move_err;

    ttt_turn_sequencer #(.SYNC_STAGES(2)) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .cell_btn    (cell_btn),
        .comp_button (comp_button),
        .cell_led    (cell_led),
        .p1_turn     (p1_turn),
        .p2_turn     (p2_turn),
        .p1_win      (p1_win),
        .p2_win      (p2_win),
        .grid_full   (grid_full),
        .move_err    (move_err)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [17:0] led;
        logic        p1t, p2t, p1w, p2w, full, err;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_errors = 0;

    int   g[9];
    int   turn;
    bit   over, m_p1w, m_p2w, m_full;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        for (int k = 0; k < 9; k++) g[k] = 0;
        turn = 1; over = 0; m_p1w = 0; m_p2w = 0; m_full = 0;
    endtask

    function automatic bit won(input int p);
        return (g[0]==p && g[1]==p && g[2]==p) || (g[3]==p && g[4]==p && g[5]==p) ||
               (g[6]==p && g[7]==p && g[8]==p) || (g[0]==p && g[3]==p && g[6]==p) ||
               (g[1]==p && g[4]==p && g[7]==p) || (g[2]==p && g[5]==p && g[8]==p) ||
               (g[0]==p && g[4]==p && g[8]==p) || (g[2]==p && g[4]==p && g[6]==p);
    endfunction

    task automatic place(input int idx);
        bit all;
        g[idx] = turn;
        all = 1;
        for (int k = 0; k < 9; k++) if (g[k] == 0) all = 0;
        if (won(turn)) begin
            if (turn == 1) m_p1w = 1; else m_p2w = 1;
            m_full = all; over = 1;
        end else if (all) begin
            m_full = 1; over = 1;
        end else begin
            turn = 3 - turn;
        end
    endtask

    task automatic model_step(input logic [8:0] mask, input logic comp, output bit err);
        int n, idx;
        err = 0;
        if (over) return;
        n = $countones(mask);
        idx = -1;
        for (int k = 0; k < 9; k++) if (mask[k]) idx = k;
        if (n >= 2) err = 1;
        else if (n == 1) begin
            if (g[idx] != 0) err = 1;
            else place(idx);
        end else if (comp && COMP_EN && turn == 2) begin
            idx = -1;
            for (int k = 8; k >= 0; k--) if (g[k] == 0) idx = k;
            if (idx >= 0) place(idx);
        end
    endtask

    task automatic do_move(input string tag, input logic [8:0] mask, input logic comp);
        exp_t e;
        bit   err;
        model_step(mask, comp, err);
        e.led = '0;
        for (int k = 0; k < 9; k++) e.led[2*k +: 2] = 2'(g[k]);
        e.p1t = !over && turn == 1; e.p2t = !over && turn == 2;
        e.p1w = m_p1w; e.p2w = m_p2w; e.full = m_full; e.err = err;
        sb.push_back(e);
        @(negedge clk);
        cell_btn = mask; comp_button = comp;
        repeat (3) @(posedge clk);
        #1;
        e = sb.pop_front();
        check({tag, " led"}, 32'(cell_led), 32'(e.led));
        check({tag, " err"}, 32'(move_err), 32'(e.err));
        @(posedge clk);
        #1;
        check({tag, " err_pulse"}, 32'(move_err), 32'd0);
        check({tag, " p1_turn"}, 32'(p1_turn), 32'(e.p1t));
        check({tag, " p2_turn"}, 32'(p2_turn), 32'(e.p2t));
        check({tag, " wins"}, 32'({p1_win, p2_win}), 32'({e.p1w, e.p2w}));
        check({tag, " full"}, 32'(grid_full), 32'(e.full));
        repeat (2) @(posedge clk);
        @(negedge clk);
        cell_btn = '0; comp_button = 1'b0;
        repeat (4) @(negedge clk);
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, " led"}, 32'(cell_led), 32'd0);
        check({tag, " turns"}, 32'({p1_turn, p2_turn}), 32'b10);
        check({tag, " wins"}, 32'({p1_win, p2_win}), 32'd0);
        check({tag, " full"}, 32'(grid_full), 32'd0);
        check({tag, " err"}, 32'(move_err), 32'd0);
    endtask

    task automatic do_reset(input string tag);
        reset_n = 1'b0; cell_btn = '0; comp_button = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_reset_vals(tag);
        @(negedge clk);
        reset_n = 1'b1;
        model_reset();
        repeat (2) @(negedge clk);
    endtask

    initial begin
        model_reset();
        do_reset("rst0");

        do_move("comp_in_p1", 9'h000, 1'b1);
        do_move("p1_a", 9'h001, 1'b0);
        do_move("p2_a_occ", 9'h001, 1'b0);
        do_move("p2_multi", 9'h006, 1'b0);
        do_move("p2_comp", 9'h000, 1'b1);

        do_reset("rst1");
        do_move("w_p1_a", 9'h001, 1'b0);
        do_move("w_p2_d", 9'h008, 1'b0);
        do_move("w_p1_b", 9'h002, 1'b0);
        do_move("w_p2_e", 9'h010, 1'b0);
        do_move("w_p1_c", 9'h004, 1'b0);
        do_move("over_g", 9'h040, 1'b0);
        do_move("over_multi", 9'h180, 1'b1);

        do_reset("rst2");
        do_move("v_p1_a", 9'h001, 1'b0);
        do_move("v_p2_d", 9'h008, 1'b0);
        do_move("v_p1_b", 9'h002, 1'b0);
        do_move("v_p2_e", 9'h010, 1'b0);
        do_move("v_p1_h", 9'h080, 1'b0);
        do_move("v_p2_f", 9'h020, 1'b0);

        do_reset("rst3");
        do_move("d_a", 9'h001, 1'b0);
        do_move("d_b", 9'h002, 1'b0);
        do_move("d_c", 9'h004, 1'b0);
        do_move("d_e", 9'h010, 1'b0);
        do_move("d_d", 9'h008, 1'b0);
        do_move("d_f", 9'h020, 1'b0);
        do_move("d_h", 9'h080, 1'b0);
        do_move("d_g", 9'h040, 1'b0);
        do_move("d_i", 9'h100, 1'b0);

        do_reset("rst4");
        @(negedge clk);
        cell_btn = 9'h010;
        repeat (3) @(posedge clk);
        #1;
        check("mid_check led", 32'(cell_led), 32'h100);
        reset_n = 1'b0;
        #1;
        check_reset_vals("mid_check_rst");
        @(negedge clk);
        cell_btn = '0;
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        model_reset();
        repeat (2) @(negedge clk);
        do_move("post_rst_e", 9'h010, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

`default_nettype wire
